// File: rtl/forward_scoreboard.sv
// Forwarding and load-use hazard unit: shadows in-flight register writes from EX to WB,
// picks operand forwarding sources in ID and registers them into EX, and counts stall cycles.
module forward_scoreboard #(
  parameter int unsigned NREAD      = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SELW       = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [NREAD*5-1:0]    id_rsel,
  input  logic [4:0]            id_wsel,
  input  logic                  id_regwr,
  input  logic                  id_memrd,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [NREAD*SELW-1:0] ex_fwd_sel,
  output logic [15:0]           stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] wsel;
    logic       regwr;
    logic       isload;
  } shadow_t;

  shadow_t                 p [1:DEPTH];
  shadow_t                 id_entry;
  logic [NREAD*SELW-1:0]   fwd_sel_d;
  logic [NREAD-1:0]        hazard;
  logic                    take;

  // Scan oldest-to-youngest so the youngest match overwrites; p[DEPTH] is never
  // consulted because the register file is write-before-read.
  always_comb begin
    fwd_sel_d = '0;
    hazard    = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
        if (p[k].valid && p[k].regwr && (p[k].wsel == id_rsel[5*i +: 5]) &&
            (id_rsel[5*i +: 5] != 5'd0)) begin
          fwd_sel_d[SELW*i +: SELW] = SELW'(k);
          hazard[i]                 = p[k].isload && (k < LOAD_STAGE);
        end
      end
    end
  end

  always_comb begin
    stall    = id_valid && !flush && (|hazard);
    take     = id_valid && !flush && !stall;
    id_entry = '{valid: 1'b1, wsel: id_wsel, regwr: id_regwr, isload: id_memrd};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        p[k] <= '0;
      end
      ex_fwd_sel <= '0;
      stall_cnt  <= '0;
    end else if (en) begin
      for (int unsigned k = DEPTH; k >= 2; k--) begin
        p[k] <= p[k-1];
      end
      p[1]       <= take ? id_entry : '0;
      ex_fwd_sel <= take ? fwd_sel_d : '0;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign ex_valid = p[1].valid;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed scenarios plus random traffic against a queue-based
// model of in-flight instructions, and a deep-pipeline instance driven to counter saturation.
module tb_forward_scoreboard;

  localparam int DEPTH      = 3;
  localparam int LOAD_STAGE = 2;
  localparam int SELW       = 2;

  logic        CLK;
  logic        RST;
  logic        en;
  logic        flush;
  logic        id_valid;
  logic [9:0]  id_rsel;
  logic [4:0]  id_wsel;
  logic        id_regwr;
  logic        id_memrd;
  logic        stall;
  logic        ex_valid;
  logic [3:0]  ex_fwd_sel;
  logic [15:0] stall_cnt;

  logic        s_rst;
  logic        s_stall;
  logic        s_ex_valid;
  logic [7:0]  s_sel;
  logic [15:0] s_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  forward_scoreboard #(.NREAD(2), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .id_valid(id_valid),
    .id_rsel(id_rsel), .id_wsel(id_wsel), .id_regwr(id_regwr), .id_memrd(id_memrd),
    .stall(stall), .ex_valid(ex_valid), .ex_fwd_sel(ex_fwd_sel), .stall_cnt(stall_cnt)
  );

  // Deep load pipeline: a chain of dependent loads stalls 15 of every 16 cycles.
  forward_scoreboard #(.NREAD(2), .DEPTH(16), .LOAD_STAGE(16)) sat (
    .CLK(CLK), .RST(s_rst), .en(1'b1), .flush(1'b0), .id_valid(1'b1),
    .id_rsel({5'd4, 5'd4}), .id_wsel(5'd4), .id_regwr(1'b1), .id_memrd(1'b1),
    .stall(s_stall), .ex_valid(s_ex_valid), .ex_fwd_sel(s_sel), .stall_cnt(s_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit valid;
    int wsel;
    bit regwr;
    bit isload;
  } ent_t;

  ent_t q[$];   // q[0] = instruction now in EX, q[n] = n stages further down
  int   m_sel[2];
  int   m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input bit v, input int rs0, input int rs1, input int wd,
                        input bit rw, input bit ld);
    id_valid = v;
    id_rsel  = {5'(rs1), 5'(rs0)};
    id_wsel  = 5'(wd);
    id_regwr = rw;
    id_memrd = ld;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick(input string tag);
    int   k[2];
    bit   ld[2];
    bit   hz;
    bit   m_stall;
    bit   take;
    ent_t e;
    int   rs;
    #1;
    hz = 0;
    for (int i = 0; i < 2; i++) begin
      k[i]  = 0;
      ld[i] = 0;
      rs    = int'(id_rsel[5*i +: 5]);
      for (int j = 0; j < q.size() && j < DEPTH - 1; j++) begin
        if (k[i] == 0 && rs != 0 && q[j].valid && q[j].regwr && q[j].wsel == rs) begin
          k[i]  = j + 1;
          ld[i] = q[j].isload;
        end
      end
      if (k[i] != 0 && ld[i] && k[i] < LOAD_STAGE) hz = 1;
    end
    m_stall = id_valid && !flush && hz;
    take    = id_valid && !flush && !m_stall;
    chk({tag, ".stall"}, 32'(stall), 32'(m_stall));
    @(posedge CLK);
    if (RST) begin
      q.delete();
      m_sel = '{0, 0};
      m_cnt = 0;
    end else if (en) begin
      if (m_stall && m_cnt < 65535) m_cnt++;
      if (take) e = '{1'b1, int'(id_wsel), id_regwr, id_memrd};
      else      e = '{1'b0, 0, 1'b0, 1'b0};
      q.push_front(e);
      if (q.size() > DEPTH) void'(q.pop_back());
      if (take) m_sel = k;
      else      m_sel = '{0, 0};
    end
    #1;
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'((q.size() > 0) && q[0].valid));
    chk({tag, ".fwd_sel"}, 32'(ex_fwd_sel), 32'({SELW'(m_sel[1]), SELW'(m_sel[0])}));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    @(negedge CLK);
  endtask

  initial begin
    m_sel = '{0, 0};
    m_cnt = 0;
    RST   = 1'b1;
    s_rst = 1'b1;
    en    = 1'b1;
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0);
    @(negedge CLK);

    // Reset state
    tick("rst0");
    tick("rst1");
    chk("rst.ex_valid", 32'(ex_valid), 32'd0);
    chk("rst.fwd_sel", 32'(ex_fwd_sel), 32'd0);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    RST = 1'b0;

    // Back-to-back dependence on port0
    set_id(1, 1, 2, 3, 1, 0); tick("t1.add");
    set_id(1, 3, 5, 6, 1, 0); tick("t1.sub");
    chk("t1.sel", 32'(ex_fwd_sel), 32'b0001);

    // Distance-2 dependence on port1
    set_id(1, 0, 0, 3, 1, 0);   tick("t2.prod");
    set_id(1, 8, 9, 10, 1, 0);  tick("t2.indep");
    set_id(1, 11, 3, 12, 1, 0); tick("t2.cons");
    chk("t2.sel", 32'(ex_fwd_sel), 32'b1000);

    // Load-use: one stall, bubble, then forward from MEM latch
    RST = 1'b1; tick("t3.rst"); RST = 1'b0;
    set_id(1, 1, 0, 4, 1, 1); tick("t3.lw");
    set_id(1, 4, 0, 13, 1, 0);
    #1; chk("t3.stall", 32'(stall), 32'd1);
    tick("t3.use0");
    chk("t3.bubble", 32'(ex_valid), 32'd0);
    chk("t3.cnt", 32'(stall_cnt), 32'd1);
    #1; chk("t3.stall_end", 32'(stall), 32'd0);
    tick("t3.use1");
    chk("t3.sel", 32'(ex_fwd_sel), 32'b0010);
    chk("t3.valid", 32'(ex_valid), 32'd1);

    // $0 and non-writing producers never forward
    set_id(1, 1, 1, 0, 1, 0);  tick("t4.w0");
    set_id(1, 0, 0, 14, 1, 0); tick("t4.u0");
    chk("t4.sel0", 32'(ex_fwd_sel), 32'd0);
    set_id(1, 1, 1, 6, 0, 0);  tick("t4.nw");
    set_id(1, 6, 6, 15, 1, 0); tick("t4.u6");
    chk("t4.sel6", 32'(ex_fwd_sel), 32'd0);

    // Youngest of two writers wins, both ports
    set_id(1, 1, 1, 5, 1, 0);  tick("t5.w1");
    set_id(1, 2, 2, 5, 1, 0);  tick("t5.w2");
    set_id(1, 5, 5, 16, 1, 0); tick("t5.use");
    chk("t5.sel", 32'(ex_fwd_sel), 32'b0101);

    // Freeze during a load-use stall
    set_id(1, 1, 0, 7, 1, 1); tick("t6.lw");
    set_id(1, 7, 0, 17, 1, 0);
    en = 1'b0;
    tick("t6.frz0");
    tick("t6.frz1");
    #1; chk("t6.frz_stall", 32'(stall), 32'd1);
    chk("t6.frz_cnt", 32'(stall_cnt), 32'd1);
    chk("t6.frz_valid", 32'(ex_valid), 32'd1);
    en = 1'b1;
    tick("t6.run0");
    chk("t6.cnt", 32'(stall_cnt), 32'd2);
    tick("t6.run1");
    chk("t6.sel", 32'(ex_fwd_sel), 32'b0010);

    // Flush beats stall
    set_id(1, 1, 0, 8, 1, 1); tick("t6.lw2");
    set_id(1, 8, 0, 18, 1, 0);
    flush = 1'b1;
    #1; chk("t6.flush_stall", 32'(stall), 32'd0);
    tick("t6.flush");
    chk("t6.flush_bubble", 32'(ex_valid), 32'd0);
    chk("t6.flush_cnt", 32'(stall_cnt), 32'd2);
    flush = 1'b0;

    // Reset in the middle of a stall
    set_id(1, 1, 0, 9, 1, 1); tick("t6.lw3");
    set_id(1, 9, 0, 19, 1, 0);
    #1; chk("t6.pre_rst_stall", 32'(stall), 32'd1);
    RST = 1'b1; tick("t6.rst"); RST = 1'b0;
    chk("t6.rst_cnt", 32'(stall_cnt), 32'd0);
    chk("t6.rst_valid", 32'(ex_valid), 32'd0);
    chk("t6.rst_sel", 32'(ex_fwd_sel), 32'd0);
    #1; chk("t6.rst_stall", 32'(stall), 32'd0);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      RST   = ($urandom % 100) == 0;
      en    = ($urandom % 8) != 0;
      flush = ($urandom % 10) == 0;
      set_id(($urandom % 8) != 0, int'($urandom % 6), int'($urandom % 6),
             int'($urandom % 6), ($urandom % 4) != 0, ($urandom % 3) == 0);
      tick("rnd");
    end
    RST   = 1'b0;
    en    = 1'b1;
    flush = 1'b0;

    // Counter saturation on the deep instance
    s_rst = 1'b0;
    for (int c = 0; c < 70000; c++) begin
      if (c < 2 || c == 16) begin
        #1; chk("sat.stall", 32'(s_stall), 32'((c % 16) != 0));
      end
      @(posedge CLK);
      if (c == 15) begin
        #1; chk("sat.cnt15", 32'(s_cnt), 32'd15);
      end
      @(negedge CLK);
    end
    #1; chk("sat.cnt_max", 32'(s_cnt), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
